cmd_parser: RTL and testbench
=============================

# cmd_parser

Byte-stream command parser between `uart_rx` and the console-mux configuration/response logic. Takes received bytes, decodes a one-byte opcode plus optional big-endian payload, and holds the live mux configuration: a 16-bit output-enable mask and a 32-bit pin map. Write commands update the configuration atomically. Read commands go to the downstream TX responder through a valid/ready handshake.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 640: max clocks allowed between payload bytes before the frame is aborted (≥2).
- `EN_RESET`, default 16'hAA55: reset value of `enable_mask`.
- `MAP_RESET`, default 32'h0000_0000: reset value of `pin_map`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_ready`  in  1  byte-available flag from `uart_rx`; level or pulse; a byte event is its rising edge.
- `rx_data`  in  8  received byte; valid when `rx_ready` is high.
- `enable_mask`  out  16  live output-enable mask to `mux`.
- `pin_map`  out  32  live selector map to `mux`.
- `cfg_update`  out  1  one-cycle pulse after any committed write.
- `rd_valid`  out  1  read request pending.
- `rd_sel`  out  1  0 = enable mask, 1 = pin map; stable while `rd_valid`.
- `rd_ready`  in  1  responder accepts request.
- `err`  out  1  one-cycle pulse on protocol error.
- `err_count`  out  8  saturating error counter.

## Operation
- Byte event: `rx_ready` = 1 and registered `rx_ready_q` = 0. `rx_data` is sampled on that same edge. At most one event per `rx_ready` high period.
- Opcodes:
  - 0x01 READ_EN (no payload).
  - 0x02 READ_MAP (no payload).
  - 0x03 WRITE_EN (2 bytes, MSB first).
  - 0x04 WRITE_MAP (4 bytes, MSB first).
  - Any other byte in IDLE: `err`, stay IDLE.
- FSM states:
  - IDLE: on a byte event, decode the opcode. Reads post a request. Writes load `remaining` (2 or 4), clear the shadow register, clear the timeout counter, and go to PAYLOAD.
  - PAYLOAD: on a byte event, shift into the shadow (`shadow <= {shadow[23:0], byte}`), decrement `remaining`, and clear the timeout counter.
    - On the final byte: copy shadow[15:0] to `enable_mask`, or shadow[31:0] to `pin_map`. Both update on that edge. Return to IDLE.
    - With no byte event, the counter increments. At `TIMEOUT_CYCLES-1`: `err`, discard the shadow (live registers untouched), go to IDLE.
- Read request:
  - `rd_valid` rises and `rd_sel` is set on the edge after opcode acceptance.
  - It holds until a cycle with `rd_valid && rd_ready`, and drops on the following edge.
  - A read opcode while `rd_valid` is already high is dropped with `err`; the pending request is unchanged.
  - Write commands proceed regardless of `rd_valid`.
- `err_count` increments on every `err` pulse and saturates at 8'hFF.
- Reset values:
  - `enable_mask` = EN_RESET, `pin_map` = MAP_RESET.
  - `cfg_update`, `rd_valid`, `rd_sel`, `err` = 0; `err_count` = 0.
  - State IDLE; `rx_ready_q` = 0.

## Timing
- Byte event at edge N:
  - Opcode decode and state change take effect at N.
  - `rd_valid` is visible after N.
  - Final payload byte at N: live register updated at N, `cfg_update` high for cycle N+1 only.
- Throughput: one byte per two clocks minimum (rising edge requires a low cycle).
- Timeout and byte event in the same cycle: the byte wins and the counter clears.
- `err` from an invalid opcode or a dropped read: pulse in the cycle after the byte edge.
- `err` from a timeout: pulse in the cycle after the state leaves PAYLOAD.
- `rd_ready` while `rd_valid` = 0 is ignored.
- `rst_n` low mid-frame: immediate abort, shadow lost, live registers return to reset values. No `err` and no `cfg_update` on exit from reset.
- `rx_ready` high while `rst_n` deasserts: `rx_ready_q` resets to 0, so this counts as a byte event on the first active edge. The bench must hold `rx_ready` low across reset release.

## Structure
- Shared package `comm_pkg`: opcode constants, payload lengths, FSM state typedef, default `EN_RESET`.
- Sub-module `byte_strobe`: registers `rx_ready`, produces a one-cycle `byte_evt` and a latched byte. Reused by other RX consumers.
- Timeout counter width: $clog2(TIMEOUT_CYCLES).

## Test plan
- Reset → `enable_mask` = 16'hAA55, `pin_map` = 0, `rd_valid` = 0, `err_count` = 0.
- Bytes 0x03, 0x12, 0x34 → `enable_mask` = 16'h1234 exactly on the last-byte edge. `cfg_update` pulses once. `pin_map` unchanged.
- Bytes 0x04, 0xDE, 0xAD, 0xBE, 0xEF → `pin_map` = 32'hDEADBEEF. Then 0x02 with `rd_ready` held low 5 cycles → `rd_valid` = 1, `rd_sel` = 1 throughout; it drops the edge after `rd_ready` is asserted.
- 0x03, 0x55, then idle `TIMEOUT_CYCLES` → one `err` pulse, `err_count` = 1, `enable_mask` unchanged. Next 0x01 → `rd_valid` = 1, `rd_sel` = 0.
- 0x01, then 0x02 while `rd_valid` is pending → `err`; `rd_sel` stays 0. Invalid byte 0x7F → `err`. Drive 300 invalid bytes → `err_count` saturates at 8'hFF.
- Assert `rst_n` low after 0x04, 0x11, 0x22 → `pin_map` = 0 and state IDLE. A subsequent complete 0x03 frame commits correctly.

Source files
------------

// File: rtl/comm_pkg.sv
// Shared definitions for the console command path.
// Holds the opcode encodings, payload lengths, the parser FSM state type
// and the default reset value of the output-enable mask.
package comm_pkg;

    localparam logic [7:0] OP_READ_EN   = 8'h01;
    localparam logic [7:0] OP_READ_MAP  = 8'h02;
    localparam logic [7:0] OP_WRITE_EN  = 8'h03;
    localparam logic [7:0] OP_WRITE_MAP = 8'h04;

    localparam logic [2:0] LEN_EN  = 3'd2;
    localparam logic [2:0] LEN_MAP = 3'd4;

    localparam logic [15:0] EN_RESET_DEF = 16'hAA55;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PAYLOAD = 1'b1
    } parse_state_t;

    // Payload byte count for a write opcode; zero for anything else.
    function automatic logic [2:0] payload_len(input logic [7:0] op);
        case (op)
            OP_WRITE_EN:  payload_len = LEN_EN;
            OP_WRITE_MAP: payload_len = LEN_MAP;
            default:      payload_len = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/byte_strobe.sv
// Rising-edge detector for a UART receive flag.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   rx_ready_i    byte-available flag (level or pulse)
//   rx_data_i     received byte, valid while rx_ready_i is high
//   byte_evt_o    high in the cycle where rx_ready_i rises (combinational,
//                 so the consumer acts on the same edge the byte arrives)
//   byte_o        the byte: rx_data_i during the event, last captured
//                 byte otherwise
module byte_strobe (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_ready_i,
    input  logic [7:0] rx_data_i,
    output logic       byte_evt_o,
    output logic [7:0] byte_o
);

    logic       rx_ready_q;
    logic [7:0] byte_q;

    assign byte_evt_o = rx_ready_i & ~rx_ready_q;
    assign byte_o     = byte_evt_o ? rx_data_i : byte_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ready_q <= 1'b0;
            byte_q     <= 8'h00;
        end else begin
            rx_ready_q <= rx_ready_i;
            if (byte_evt_o) byte_q <= rx_data_i;
        end
    end

endmodule

// File: rtl/cmd_parser.sv
// Byte-stream command parser for the console mux.
// Decodes a one-byte opcode plus optional big-endian payload and holds the
// live mux configuration. Writes commit atomically on the last payload
// byte; reads are posted to the TX responder over a valid/ready handshake.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   rx_ready, rx_data  byte stream from uart_rx (event = rising rx_ready)
//   enable_mask        live 16-bit output-enable mask
//   pin_map            live 32-bit selector map
//   cfg_update         one-cycle pulse after a committed write
//   rd_valid, rd_sel   pending read request (0 = mask, 1 = map)
//   rd_ready           responder accepts the request
//   err                one-cycle pulse on a protocol error
//   err_count          saturating error counter
module cmd_parser
    import comm_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 640,
    parameter logic [15:0] EN_RESET       = EN_RESET_DEF,
    parameter logic [31:0] MAP_RESET      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic [15:0] enable_mask,
    output logic [31:0] pin_map,
    output logic        cfg_update,
    output logic        rd_valid,
    output logic        rd_sel,
    input  logic        rd_ready,
    output logic        err,
    output logic [7:0]  err_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic       byte_evt;
    logic [7:0] byte_val;

    byte_strobe u_strobe (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_ready_i (rx_ready),
        .rx_data_i  (rx_data),
        .byte_evt_o (byte_evt),
        .byte_o     (byte_val)
    );

    parse_state_t state_q, state_d;
    logic [2:0]   rem_q, rem_d;
    logic [31:0]  shadow_q, shadow_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic         is_map_q, is_map_d;
    logic [15:0]  en_q, en_d;
    logic [31:0]  map_q, map_d;
    logic         cfg_q, cfg_d;
    logic         rd_valid_q, rd_valid_d;
    logic         rd_sel_q, rd_sel_d;
    logic         err_q, err_d;
    logic [7:0]   err_cnt_q, err_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rem_q      <= 3'd0;
            shadow_q   <= 32'h0;
            tmo_q      <= '0;
            is_map_q   <= 1'b0;
            en_q       <= EN_RESET;
            map_q      <= MAP_RESET;
            cfg_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_sel_q   <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            shadow_q   <= shadow_d;
            tmo_q      <= tmo_d;
            is_map_q   <= is_map_d;
            en_q       <= en_d;
            map_q      <= map_d;
            cfg_q      <= cfg_d;
            rd_valid_q <= rd_valid_d;
            rd_sel_q   <= rd_sel_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        shadow_d   = shadow_q;
        tmo_d      = tmo_q;
        is_map_d   = is_map_q;
        en_d       = en_q;
        map_d      = map_q;
        cfg_d      = 1'b0;
        rd_valid_d = rd_valid_q;
        rd_sel_d   = rd_sel_q;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;

        // Handshake retires the request; rd_ready alone is ignored.
        if (rd_valid_q && rd_ready) rd_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (byte_evt) begin
                    case (byte_val)
                        OP_READ_EN, OP_READ_MAP: begin
                            // Only one outstanding read; a second one is
                            // dropped even if the first retires this cycle.
                            if (rd_valid_q) begin
                                err_d = 1'b1;
                            end else begin
                                rd_valid_d = 1'b1;
                                rd_sel_d   = (byte_val == OP_READ_MAP);
                            end
                        end
                        OP_WRITE_EN, OP_WRITE_MAP: begin
                            rem_d    = payload_len(byte_val);
                            is_map_d = (byte_val == OP_WRITE_MAP);
                            shadow_d = 32'h0;
                            tmo_d    = '0;
                            state_d  = ST_PAYLOAD;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            ST_PAYLOAD: begin
                // A byte beats a coincident timeout.
                if (byte_evt) begin
                    shadow_d = {shadow_q[23:0], byte_val};
                    rem_d    = rem_q - 3'd1;
                    tmo_d    = '0;
                    if (rem_q == 3'd1) begin
                        if (is_map_q) map_d = shadow_d;
                        else          en_d  = shadow_d[15:0];
                        cfg_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // Abandon the frame; the shadow is simply never used.
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    assign enable_mask = en_q;
    assign pin_map     = map_q;
    assign cfg_update  = cfg_q;
    assign rd_valid    = rd_valid_q;
    assign rd_sel      = rd_sel_q;
    assign err         = err_q;
    assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_cmd_parser.sv
// Directed self-checking bench for cmd_parser.
module tb_cmd_parser;

    logic        clk;
    logic        rst_n;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic [15:0] enable_mask;
    logic [31:0] pin_map;
    logic        cfg_update;
    logic        rd_valid;
    logic        rd_sel;
    logic        rd_ready;
    logic        err;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    cmd_parser #(
        .TIMEOUT_CYCLES (640),
        .EN_RESET       (16'hAA55),
        .MAP_RESET      (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .enable_mask (enable_mask),
        .pin_map     (pin_map),
        .cfg_update  (cfg_update),
        .rd_valid    (rd_valid),
        .rd_sel      (rd_sel),
        .rd_ready    (rd_ready),
        .err         (err),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Raise rx_ready for one cycle; returns at the negedge just after the
    // byte-event edge, i.e. in the cycle where its effects are first visible.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_ready = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        int seen;
        rst_n    = 1'b0;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_en",     {16'h0, enable_mask}, 32'h0000_AA55);
        chk("rst_map",    pin_map,              32'h0);
        chk("rst_rdv",    {31'h0, rd_valid},    32'h0);
        chk("rst_errcnt", {24'h0, err_count},   32'h0);
        chk("rst_cfg",    {31'h0, cfg_update},  32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // WRITE_EN 0x1234
        send_byte(8'h03);
        send_byte(8'h12);
        chk("wen_mid", {16'h0, enable_mask}, 32'h0000_AA55);
        send_byte(8'h34);
        chk("wen_val", {16'h0, enable_mask}, 32'h0000_1234);
        chk("wen_cfg", {31'h0, cfg_update},  32'h1);
        chk("wen_map", pin_map,              32'h0);
        @(negedge clk);
        chk("wen_cfg_once", {31'h0, cfg_update}, 32'h0);

        // WRITE_MAP 0xDEADBEEF
        send_byte(8'h04);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        chk("wmap_mid", pin_map, 32'h0);
        send_byte(8'hEF);
        chk("wmap_val", pin_map,             32'hDEAD_BEEF);
        chk("wmap_cfg", {31'h0, cfg_update}, 32'h1);
        chk("wmap_en",  {16'h0, enable_mask}, 32'h0000_1234);

        // READ_MAP held off by rd_ready for 5 cycles
        send_byte(8'h02);
        chk("rmap_vld", {31'h0, rd_valid}, 32'h1);
        chk("rmap_sel", {31'h0, rd_sel},   32'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rmap_hold", {30'h0, rd_valid, rd_sel}, 32'h3);
        end
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        chk("rmap_drop", {31'h0, rd_valid}, 32'h0);

        // Timeout mid WRITE_EN frame
        send_byte(8'h03);
        send_byte(8'h55);
        seen = 0;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            if (err) begin
                seen = k;
                break;
            end
        end
        chk("tmo_latency", seen,                  32'd640);
        chk("tmo_errcnt",  {24'h0, err_count},    32'd1);
        chk("tmo_en",      {16'h0, enable_mask},  32'h0000_1234);
        chk("tmo_nocfg",   {31'h0, cfg_update},   32'h0);
        @(negedge clk);
        chk("tmo_err_once", {31'h0, err}, 32'h0);

        // READ_EN then a second read while pending
        send_byte(8'h01);
        chk("ren_vld", {31'h0, rd_valid}, 32'h1);
        chk("ren_sel", {31'h0, rd_sel},   32'h0);
        send_byte(8'h02);
        chk("drop_err",    {31'h0, err},         32'h1);
        chk("drop_sel",    {30'h0, rd_valid, rd_sel}, 32'h2);
        chk("drop_errcnt", {24'h0, err_count},   32'd2);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        chk("ren_drop", {31'h0, rd_valid}, 32'h0);

        // Invalid opcode
        send_byte(8'h7F);
        chk("inv_err",    {31'h0, err},       32'h1);
        chk("inv_errcnt", {24'h0, err_count}, 32'd3);
        @(negedge clk);
        chk("inv_err_once", {31'h0, err}, 32'h0);

        // Saturation
        for (int i = 0; i < 300; i++) send_byte(8'hA5);
        chk("sat_errcnt", {24'h0, err_count}, 32'h0000_00FF);
        chk("sat_en",     {16'h0, enable_mask}, 32'h0000_1234);

        // Reset in the middle of a WRITE_MAP frame
        send_byte(8'h04);
        send_byte(8'h11);
        send_byte(8'h22);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_map",    pin_map,               32'h0);
        chk("mrst_en",     {16'h0, enable_mask},  32'h0000_AA55);
        chk("mrst_errcnt", {24'h0, err_count},    32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_quiet", {30'h0, err, cfg_update}, 32'h0);
        send_byte(8'h03);
        send_byte(8'hBE);
        send_byte(8'hEF);
        chk("post_en",  {16'h0, enable_mask}, 32'h0000_BEEF);
        chk("post_cfg", {31'h0, cfg_update},  32'h1);
        chk("post_map", pin_map,              32'h0);
        chk("post_err", {24'h0, err_count},   32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
